// File: rtl/lfsr_pkg.sv
// Shared definition of the 32-bit PRBS polynomial x^32+x^30+x^26+x^25+1.
// Imported by the generator and by the checker so that the taps are defined once.
//   LFSR_W    : register width
//   LFSR_TAPS : feedback tap mask (bits 31, 29, 25, 24)
//   lfsr_fb() : feedback bit for a given state; also the bit the generator emits
//   lfsr_state_e : checker FSM states
package lfsr_pkg;

    localparam int unsigned LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'hA300_0000;

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } lfsr_state_e;

    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream and status bundle of the PRBS checker.
//   master : the producer/observer side (drives in_valid, in_bit, clear_counts)
//   slave  : the checker side (drives locked, bit_err and the statistics)
interface prbs_checker_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             in_valid;
    logic             in_bit;
    logic             clear_counts;
    logic             locked;
    logic             bit_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] resync_count;

    modport master (
        output in_valid,
        output in_bit,
        output clear_counts,
        input  locked,
        input  bit_err,
        input  err_count,
        input  bit_count,
        input  resync_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  clear_counts,
        output locked,
        output bit_err,
        output err_count,
        output bit_count,
        output resync_count
    );

endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter used for the checker statistics.
//   clock, reset : clock and synchronous active-high reset
//   clr          : synchronous clear, wins over inc
//   inc          : count one event
//   q            : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker for x^32+x^30+x^26+x^25+1.
// Seeds its reference LFSR from 32 received bits, then predicts every following bit and
// flags mismatches. Too many errors inside one window drop lock and force a fresh seed.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : in_valid/in_bit stream, clear_counts, locked, bit_err and the
//                  saturating err_count / bit_count / resync_count statistics
module prbs_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned WINDOW     = 64,
    parameter int unsigned CNT_W      = 16
) (
    input logic           clock,
    input logic           reset,
    prbs_checker_if.slave bus
);

    localparam int unsigned WIN_W = $clog2(WINDOW + 1);
    localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);

    lfsr_state_e       state_q, state_d;
    logic [LFSR_W-1:0] s_q, s_d;
    logic [4:0]        seed_cnt_q, seed_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [ERR_W-1:0]  win_err_q, win_err_d;
    logic              bit_err_q, bit_err_d;

    logic              exp_bit;
    logic              err;
    logic [LFSR_W-1:0] seed_shift;
    logic [WIN_W-1:0]  win_cnt_inc;
    logic [ERR_W-1:0]  win_err_inc;
    logic              bit_inc;
    logic              err_inc;
    logic              resync_inc;

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        seed_cnt_d  = seed_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        bit_err_d   = 1'b0;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;
        resync_inc  = 1'b0;

        exp_bit     = lfsr_fb(s_q);
        err         = bus.in_bit ^ exp_bit;
        seed_shift  = {s_q[LFSR_W-2:0], bus.in_bit};
        win_cnt_inc = win_cnt_q + WIN_W'(1);
        win_err_inc = win_err_q + ERR_W'(err);

        if (bus.in_valid) begin
            case (state_q)
                SEED: begin
                    s_d = seed_shift;
                    if (seed_cnt_q == 5'd31) begin
                        seed_cnt_d = '0;
                        // All-zero is the LFSR lock-up state; keep seeding.
                        if (seed_shift != '0) begin
                            state_d = CHECK;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 5'd1;
                    end
                end
                CHECK: begin
                    // Advance on the prediction, never on the received bit, so one
                    // channel error stays one error.
                    s_d       = {s_q[LFSR_W-2:0], exp_bit};
                    bit_err_d = err;
                    bit_inc   = 1'b1;
                    err_inc   = err;
                    if (win_err_inc == ERR_W'(ERR_THRESH)) begin
                        state_d    = SEED;
                        s_d        = '0;
                        seed_cnt_d = '0;
                        win_cnt_d  = '0;
                        win_err_d  = '0;
                        resync_inc = 1'b1;
                    end else if (win_cnt_inc == WIN_W'(WINDOW)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_inc;
                        win_err_d = win_err_inc;
                    end
                end
                default: begin
                    state_d = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= SEED;
            s_q        <= '0;
            seed_cnt_q <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            bit_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            seed_cnt_q <= seed_cnt_d;
            win_cnt_q  <= win_cnt_d;
            win_err_q  <= win_err_d;
            bit_err_q  <= bit_err_d;
        end
    end

    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;
    logic [CNT_W-1:0] resync_count;

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (bus.clear_counts),
        .inc   (err_inc),
        .q     (err_count)
    );

    sat_counter #(.W(CNT_W)) u_bit_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (bus.clear_counts),
        .inc   (bit_inc),
        .q     (bit_count)
    );

    sat_counter #(.W(CNT_W)) u_resync_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (bus.clear_counts),
        .inc   (resync_inc),
        .q     (resync_count)
    );

    assign bus.locked       = (state_q == CHECK);
    assign bus.bit_err      = bit_err_q;
    assign bus.err_count    = err_count;
    assign bus.bit_count    = bit_count;
    assign bus.resync_count = resync_count;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker. A reference generator produces the PRBS stream;
// the driver pushes expected locked/bit_err per cycle and count checkpoints into a
// queue, and a negedge monitor pops and compares. A 4-bit-counter copy of the DUT
// sees the same stimulus to exercise saturation.
module tb_prbs_checker;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;

    prbs_checker_if #(.CNT_W(16)) bus ();
    prbs_checker_if #(.CNT_W(4))  bus4 ();

    assign bus4.in_valid     = bus.in_valid;
    assign bus4.in_bit       = bus.in_bit;
    assign bus4.clear_counts = bus.clear_counts;

    prbs_checker #(.ERR_THRESH(4), .WINDOW(64), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    prbs_checker #(.ERR_THRESH(4), .WINDOW(64), .CNT_W(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        string tag;
        bit    cnt;
        bit    lock;
        bit    berr;
        int    errc;
        int    bitc;
        int    resc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    task automatic chk(input string tag, input string fld, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s.%s @cyc %0d: got %0d, expected %0d", tag, fld, cyc, act, exp);
        end
    endtask

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    always @(negedge clock) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            if (cur.cyc != cyc) begin
                chk(cur.tag, "stale_cycle", cur.cyc, cyc);
            end else if (cur.cnt) begin
                chk(cur.tag, "err_count", int'(bus.err_count), cur.errc);
                chk(cur.tag, "bit_count", int'(bus.bit_count), cur.bitc);
                chk(cur.tag, "resync_count", int'(bus.resync_count), cur.resc);
                chk(cur.tag, "err_count4", int'(bus4.err_count), sat4(cur.errc));
                chk(cur.tag, "bit_count4", int'(bus4.bit_count), sat4(cur.bitc));
                chk(cur.tag, "resync_count4", int'(bus4.resync_count), sat4(cur.resc));
            end else begin
                chk(cur.tag, "locked", int'(bus.locked), int'(cur.lock));
                chk(cur.tag, "bit_err", int'(bus.bit_err), int'(cur.berr));
            end
        end
    end

    // Reference generator: emitted bit is the feedback bit.
    logic [31:0] gs;
    task automatic gen_bit(output bit o);
        o  = gs[31] ^ gs[29] ^ gs[25] ^ gs[24];
        gs = {gs[30:0], o};
    endtask

    // Drive one cycle; expectations are for the outputs right after this edge.
    task automatic step(input bit r, input bit v, input bit b, input bit c,
                        input bit el, input bit eb, input string tag);
        exp_t e;
        reset            = r;
        bus.in_valid     = v;
        bus.in_bit       = b;
        bus.clear_counts = c;
        @(posedge clock);
        #1;
        e.cyc = cyc; e.tag = tag; e.cnt = 1'b0; e.lock = el; e.berr = eb;
        e.errc = 0; e.bitc = 0; e.resc = 0;
        sb.push_back(e);
    endtask

    task automatic checkpoint(input string tag, input int errc, input int bitc, input int resc);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.cnt = 1'b1; e.lock = 1'b0; e.berr = 1'b0;
        e.errc = errc; e.bitc = bitc; e.resc = resc;
        sb.push_back(e);
    endtask

    task automatic seed32(input logic [31:0] seed, input string tag);
        bit b;
        gs = seed;
        for (int i = 0; i < 32; i++) begin
            gen_bit(b);
            step(1'b0, 1'b1, b, 1'b0, (i == 31), 1'b0, tag);
        end
    endtask

    task automatic clean(input int n, input string tag);
        bit b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(1'b0, 1'b1, b, 1'b0, 1'b1, 1'b0, tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b;
        bit e;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_bit = 1'b0;
        bus.clear_counts = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst");
        checkpoint("rst", 0, 0, 0);

        // Clean lock and 1000 checked bits
        seed32(32'h8EAF_696C, "t1_seed");
        clean(1000, "t1_chk");
        checkpoint("t1_cnt", 0, 1000, 0);

        // Single error at checked bit 100
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t2_clr");
        checkpoint("t2_clr", 0, 0, 0);
        for (int i = 0; i < 150; i++) begin
            gen_bit(b);
            step(1'b0, 1'b1, b ^ (i == 100), 1'b0, 1'b1, (i == 100), "t2_chk");
        end
        checkpoint("t2_cnt", 1, 150, 0);

        // Four errors within 20 checked bits drop lock; then relock
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t3_rst");
        checkpoint("t3_rst", 0, 0, 0);
        seed32(32'h1357_9BDF, "t3_seed");
        for (int i = 0; i < 30; i++) begin
            e = (i == 10) || (i == 15) || (i == 20) || (i == 29);
            gen_bit(b);
            step(1'b0, 1'b1, b ^ e, 1'b0, (i != 29), e, "t3_err");
        end
        checkpoint("t3_loss", 4, 30, 1);
        for (int i = 0; i < 32; i++) begin
            gen_bit(b);
            step(1'b0, 1'b1, b, 1'b0, (i == 31), 1'b0, "t3_reseed");
        end
        clean(20, "t3_chk");
        checkpoint("t3_relock", 4, 50, 1);

        // All-zero seed is rejected
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_rst");
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t4_zero");
        end
        seed32(32'h8EAF_696C, "t4_seed");
        clean(10, "t4_chk");
        checkpoint("t4_cnt", 0, 10, 0);

        // Errored bit then a 10-cycle gap: bit_err drops, counters and lock hold
        gen_bit(b);
        step(1'b0, 1'b1, ~b, 1'b0, 1'b1, 1'b1, "t5_err");
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, i[0], 1'b0, 1'b1, 1'b0, "t5_gap");
        end
        checkpoint("t5_gap", 1, 11, 0);
        clean(20, "t5_resume");
        checkpoint("t5_resume", 1, 31, 0);

        // clear_counts on an errored bit, then reset mid-CHECK with an errored bit
        gen_bit(b);
        step(1'b0, 1'b1, ~b, 1'b1, 1'b1, 1'b1, "t6_clr_err");
        checkpoint("t6_clr", 0, 0, 0);
        gen_bit(b);
        step(1'b1, 1'b1, ~b, 1'b0, 1'b0, 1'b0, "t6_rst");
        checkpoint("t6_rst", 0, 0, 0);
        seed32(32'hCAFE_F00D, "t6_seed");
        clean(5, "t6_chk");
        checkpoint("t6_relock", 0, 5, 0);

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "idle");
        @(negedge clock);
        @(negedge clock);
        chk("end", "scoreboard_left", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
